dvi_decoder: RTL

Per-channel TMDS receive decoder, the receive-side counterpart of the DVI encoder. It accepts raw 10-bit words from a deserializer at pixel rate, whose bit alignment is arbitrary, and finds the word boundary by locking onto control-token runs. It then decodes each word into 8-bit pixel data or a control pair (c0, c1) plus data enable. One instance is used per colour channel in the DVI receiver top.

---
 rtl/dvi_pkg.sv | 36 +++
 rtl/tmds_word_aligner.sv | 136 +++++++++++++
 rtl/dvi_decoder.sv | 92 +++++++++
 3 files changed

// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - TMDS control tokens, aligner states and default timing for the DVI receive path
package dvi_pkg;

   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

   localparam int DEF_CTRL_RUN       = 8;
   localparam int DEF_SEARCH_TIMEOUT = 4096;
   localparam int DEF_LOCK_TIMEOUT   = 65536;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } align_state_e;

   function automatic logic is_ctrl_token(input logic [9:0] w);
      return (w == CTRL_TOKEN_00) || (w == CTRL_TOKEN_01) ||
             (w == CTRL_TOKEN_10) || (w == CTRL_TOKEN_11);
   endfunction

   // Returns {c1, c0}; non-token words map to 00 and must be filtered by the caller.
   function automatic logic [1:0] ctrl_of_token(input logic [9:0] w);
      logic [1:0] c;
      case (w)
         CTRL_TOKEN_01: c = 2'b01;
         CTRL_TOKEN_10: c = 2'b10;
         CTRL_TOKEN_11: c = 2'b11;
         default:       c = 2'b00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - finds the TMDS word boundary by locking onto control-token runs
// Optional relock statistics counter enabled by DVI_DECODER_STATS_EN.
module tmds_word_aligner
   import dvi_pkg::*;
#(
   parameter int CTRL_RUN       = DEF_CTRL_RUN,
   parameter int SEARCH_TIMEOUT = DEF_SEARCH_TIMEOUT,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [9:0]  raw_i,
   output logic [9:0]  aligned_o,
   output logic        locked_o,
   output logic [3:0]  bit_offset_o
`ifdef DVI_DECODER_STATS_EN
   ,
   output logic [15:0] relock_cnt_o
`endif
);

   localparam int RUN_W  = $clog2(CTRL_RUN + 1);
   localparam int SRCH_W = $clog2(SEARCH_TIMEOUT);
   localparam int WD_W   = $clog2(LOCK_TIMEOUT);
   localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(CTRL_RUN);
   localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_TIMEOUT - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(LOCK_TIMEOUT - 1);

   logic [9:0]        cur_q, prev_q, aligned_q, aligned_d;
   align_state_e      state_q;
   logic [3:0]        offset_q, offset_adv;
   logic [RUN_W-1:0]  run_q, run_inc;
   logic              run_full;
   logic [SRCH_W-1:0] search_q;
   logic [WD_W-1:0]   wd_q;
   logic              locked_q;
   logic              tok;
   logic              wd_expire;

   always_comb begin
      // prev holds the earlier serial bits, so offset 0 is prev unchanged.
      aligned_d  = 10'({cur_q, prev_q} >> offset_q);
      tok        = is_ctrl_token(aligned_q);
      offset_adv = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      run_inc    = (run_q >= RUN_FULL) ? RUN_FULL : run_q + 1'b1;
      run_full   = (run_inc == RUN_FULL);
      wd_expire  = (state_q == LOCKED) && (wd_q == WD_LAST);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur_q     <= '0;
         prev_q    <= '0;
         aligned_q <= '0;
         state_q   <= SEARCH;
         offset_q  <= '0;
         run_q     <= '0;
         search_q  <= '0;
         wd_q      <= '0;
         locked_q  <= 1'b0;
      end else begin
         cur_q     <= raw_i;
         prev_q    <= cur_q;
         aligned_q <= aligned_d;
         case (state_q)
            SEARCH: begin
               if (tok) begin
                  state_q  <= VERIFY;
                  run_q    <= RUN_W'(1);
                  search_q <= '0;
               end else if (search_q == SRCH_LAST) begin
                  offset_q <= offset_adv;
                  run_q    <= '0;
                  search_q <= '0;
                  wd_q     <= '0;
               end else begin
                  search_q <= search_q + 1'b1;
               end
            end
            VERIFY: begin
               if (!tok) begin
                  state_q  <= SEARCH;
                  offset_q <= offset_adv;
                  run_q    <= '0;
                  search_q <= '0;
                  wd_q     <= '0;
               end else begin
                  run_q <= run_inc;
                  if (run_full) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                     wd_q     <= '0;
                  end
               end
            end
            LOCKED: begin
               // Expiry wins over a run completing in the same cycle.
               if (wd_expire) begin
                  state_q  <= SEARCH;
                  locked_q <= 1'b0;
                  offset_q <= offset_adv;
                  run_q    <= '0;
                  search_q <= '0;
                  wd_q     <= '0;
               end else begin
                  run_q <= tok ? run_inc : '0;
                  wd_q  <= (tok && run_full) ? '0 : wd_q + 1'b1;
               end
            end
            default: begin
               state_q  <= SEARCH;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign aligned_o    = aligned_q;
   assign locked_o     = locked_q;
   assign bit_offset_o = offset_q;

`ifdef DVI_DECODER_STATS_EN
   logic [15:0] relock_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         relock_q <= '0;
      end else if (wd_expire && (relock_q != 16'hFFFF)) begin
         relock_q <= relock_q + 16'd1;
      end
   end

   assign relock_cnt_o = relock_q;
`endif

endmodule

// File: rtl/dvi_decoder.sv
// rtl/dvi_decoder.sv - per-channel TMDS receive decoder: word alignment, data/control decode
// Optional relock_cnt output enabled by DVI_DECODER_STATS_EN.
module dvi_decoder
   import dvi_pkg::*;
#(
   parameter int CTRL_RUN       = DEF_CTRL_RUN,
   parameter int SEARCH_TIMEOUT = DEF_SEARCH_TIMEOUT,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT
) (
   input  logic        clkin,
   input  logic        rstin,
   input  logic [9:0]  raw_10bit,
   output logic [7:0]  dout,
   output logic        c0,
   output logic        c1,
   output logic        de,
   output logic        locked,
   output logic [3:0]  bit_offset
`ifdef DVI_DECODER_STATS_EN
   ,
   output logic [15:0] relock_cnt
`endif
);

   logic [9:0] aligned;
   logic [7:0] q, data_d, dout_d, dout_q;
   logic [1:0] tok_c;
   logic       de_d, de_q, c0_d, c0_q, c1_d, c1_q;

   tmds_word_aligner #(
      .CTRL_RUN       (CTRL_RUN),
      .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
      .LOCK_TIMEOUT   (LOCK_TIMEOUT)
   ) u_aligner (
      .clk_i        (clkin),
      .rst_i        (rstin),
      .raw_i        (raw_10bit),
      .aligned_o    (aligned),
      .locked_o     (locked),
      .bit_offset_o (bit_offset)
`ifdef DVI_DECODER_STATS_EN
      ,
      .relock_cnt_o (relock_cnt)
`endif
   );

   always_comb begin
      q         = aligned[9] ? ~aligned[7:0] : aligned[7:0];
      data_d    = '0;
      data_d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         data_d[i] = aligned[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
      tok_c  = ctrl_of_token(aligned);
      dout_d = '0;
      de_d   = 1'b0;
      c0_d   = 1'b0;
      c1_d   = 1'b0;
      if (locked) begin
         if (is_ctrl_token(aligned)) begin
            c1_d = tok_c[1];
            c0_d = tok_c[0];
         end else begin
            // Sync bits keep the last token value across active video.
            dout_d = data_d;
            de_d   = 1'b1;
            c0_d   = c0_q;
            c1_d   = c1_q;
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (rstin) begin
         dout_q <= '0;
         de_q   <= 1'b0;
         c0_q   <= 1'b0;
         c1_q   <= 1'b0;
      end else begin
         dout_q <= dout_d;
         de_q   <= de_d;
         c0_q   <= c0_d;
         c1_q   <= c1_d;
      end
   end

   assign dout = dout_q;
   assign de   = de_q;
   assign c0   = c0_q;
   assign c1   = c1_q;

endmodule
